// File: rtl/rgb_fade_pwm.sv
// RGB LED PWM driver: one-hot palette select with optional linear fade.
// Duty changes reach the lanes only at PWM period boundaries.
module rgb_fade_pwm #(
   parameter int PWM_W    = 8,
   parameter int N_LED    = 4,
   parameter int STEP_DIV = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       btn,
   input  logic             fade_en,
   output logic [N_LED-1:0] led_r,
   output logic [N_LED-1:0] led_g,
   output logic [N_LED-1:0] led_b,
   output logic             busy,
   output logic             done,
   output logic [2:0]       color_idx
);

   localparam int PSC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PSC_W-1:0] PSC_TC = PSC_W'(STEP_DIV - 1);

   typedef logic [2:0][PWM_W-1:0] chan_t;

   function automatic logic [23:0] pal_f(input logic [2:0] i);
      logic [23:0] p;
      unique case (i)
         3'd0: p = {8'd255, 8'd0,   8'd0};
         3'd1: p = {8'd255, 8'd102, 8'd0};
         3'd2: p = {8'd255, 8'd255, 8'd0};
         3'd3: p = {8'd0,   8'd255, 8'd0};
         3'd4: p = {8'd0,   8'd0,   8'd255};
         3'd5: p = {8'd0,   8'd0,   8'd128};
         3'd6: p = {8'd128, 8'd0,   8'd128};
         default: p = {8'd255, 8'd255, 8'd255};
      endcase
      return p;
   endfunction

   // Repeat the byte's top bits below it so 8'hFF becomes all-ones.
   function automatic logic [PWM_W-1:0] expand_f(input logic [7:0] v);
      logic [15:0] t;
      t = {v, v} >> (16 - PWM_W);
      return t[PWM_W-1:0];
   endfunction

   logic [PWM_W-1:0] cnt_q, cnt_d;
   logic [PSC_W-1:0] psc_q, psc_d;
   chan_t            tgt_q, tgt_d;
   chan_t            cur_q, cur_d;
   chan_t            act_q, act_d;
   logic [2:0]       led_q, led_d;
   logic [2:0]       idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             hot;
   logic [2:0]       hot_idx;
   logic [23:0]      pal;
   chan_t            tgt_new;

   always_comb begin
      hot     = (btn != 8'd0) && ((btn & (btn - 8'd1)) == 8'd0);
      hot_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (btn[i]) hot_idx = 3'(i);
      end
      pal        = pal_f(hot_idx);
      tgt_new[2] = expand_f(pal[23:16]);
      tgt_new[1] = expand_f(pal[15:8]);
      tgt_new[0] = expand_f(pal[7:0]);
   end

   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      psc_d  = (psc_q == PSC_TC) ? '0 : psc_q + 1'b1;
      tgt_d  = tgt_q;
      cur_d  = cur_q;
      idx_d  = idx_q;
      act_d  = (&cnt_q) ? cur_q : act_q;
      busy_d = (cur_q != tgt_q);
      done_d = busy_q & ~busy_d;
      for (int c = 0; c < 3; c++) begin
         led_d[c] = (cnt_q < act_q[c]);
      end
      if (hot) begin
         tgt_d = tgt_new;
         idx_d = hot_idx;
         psc_d = '0;
         if (!fade_en) cur_d = tgt_new;
      end else if (fade_en && (psc_q == PSC_TC)) begin
         for (int c = 0; c < 3; c++) begin
            if (cur_q[c] < tgt_q[c]) begin
               cur_d[c] = cur_q[c] + 1'b1;
            end else if (cur_q[c] > tgt_q[c]) begin
               cur_d[c] = cur_q[c] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         psc_q  <= '0;
         tgt_q  <= '0;
         cur_q  <= '0;
         act_q  <= '0;
         led_q  <= '0;
         idx_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         psc_q  <= psc_d;
         tgt_q  <= tgt_d;
         cur_q  <= cur_d;
         act_q  <= act_d;
         led_q  <= led_d;
         idx_q  <= idx_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign led_r     = {N_LED{led_q[2]}};
   assign led_g     = {N_LED{led_q[1]}};
   assign led_b     = {N_LED{led_q[0]}};
   assign busy      = busy_q;
   assign done      = done_q;
   assign color_idx = idx_q;

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Randomised bench for rgb_fade_pwm against a cycle reference model.
// A second 10-bit instance checks palette width expansion.
module tb_rgb_fade_pwm;

   localparam int W  = 8;
   localparam int NL = 4;
   localparam int SD = 4;
   localparam int P  = 1 << W;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    btn;
   logic          fade_en;
   logic [NL-1:0] led_r, led_g, led_b;
   logic          busy, done;
   logic [2:0]    color_idx;
   logic [NL-1:0] led_r10, led_g10, led_b10;
   logic          busy10, done10;
   logic [2:0]    color_idx10;

   rgb_fade_pwm #(.PWM_W(W), .N_LED(NL), .STEP_DIV(SD)) u_dut (
      .clk(clk), .rst(rst), .btn(btn), .fade_en(fade_en),
      .led_r(led_r), .led_g(led_g), .led_b(led_b),
      .busy(busy), .done(done), .color_idx(color_idx)
   );

   rgb_fade_pwm #(.PWM_W(10), .N_LED(NL), .STEP_DIV(SD)) u_dut10 (
      .clk(clk), .rst(rst), .btn(btn), .fade_en(fade_en),
      .led_r(led_r10), .led_g(led_g10), .led_b(led_b10),
      .busy(busy10), .done(done10), .color_idx(color_idx10)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // reference state, channel 0=R 1=G 2=B
   int m_cnt, m_psc, m_idx;
   int m_act[3], m_cur[3], m_tgt[3];
   bit m_led[3];
   bit m_busy, m_done;

   int busy_cyc, done_cnt, r_hi, g_hi, b_hi, g10_hi, r10_hi, b10_hi;
   bit win;

   function automatic int pal_byte(input int idx, input int c);
      int p[3];
      case (idx)
         0: p = '{255, 0, 0};
         1: p = '{255, 102, 0};
         2: p = '{255, 255, 0};
         3: p = '{0, 255, 0};
         4: p = '{0, 0, 255};
         5: p = '{0, 0, 128};
         6: p = '{128, 0, 128};
         default: p = '{255, 255, 255};
      endcase
      return p[c];
   endfunction

   function automatic int expand(input int v, input int w);
      return (v << (w - 8)) | (v >> (16 - w));
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_psc = 0; m_idx = 0;
      m_busy = 0; m_done = 0;
      for (int c = 0; c < 3; c++) begin
         m_act[c] = 0; m_cur[c] = 0; m_tgt[c] = 0; m_led[c] = 0;
      end
   endtask

   task automatic model_step();
      bit differ;
      int k;
      differ = 0;
      for (int c = 0; c < 3; c++) if (m_cur[c] != m_tgt[c]) differ = 1;
      m_done = m_busy && !differ;
      m_busy = differ;
      for (int c = 0; c < 3; c++) begin
         m_led[c] = (m_cnt < m_act[c]);
         if (m_cnt == P - 1) m_act[c] = m_cur[c];
      end
      m_cnt = (m_cnt + 1) % P;
      if ($countones(btn) == 1) begin
         k = 0;
         for (int i = 0; i < 8; i++) if (btn[i]) k = i;
         m_idx = k;
         m_psc = 0;
         for (int c = 0; c < 3; c++) begin
            m_tgt[c] = expand(pal_byte(k, c), W);
            if (!fade_en) m_cur[c] = m_tgt[c];
         end
      end else begin
         if (fade_en && m_psc == SD - 1) begin
            for (int c = 0; c < 3; c++) begin
               if (m_cur[c] < m_tgt[c]) m_cur[c] = m_cur[c] + 1;
               else if (m_cur[c] > m_tgt[c]) m_cur[c] = m_cur[c] - 1;
            end
         end
         m_psc = (m_psc + 1) % SD;
      end
   endtask

   task automatic clr_stats();
      busy_cyc = 0; done_cnt = 0;
      r_hi = 0; g_hi = 0; b_hi = 0;
      g10_hi = 0; r10_hi = 0; b10_hi = 0;
   endtask

   task automatic tick();
      logic [16:0] got, exp;
      @(posedge clk);
      model_step();
      #1;
      got = {led_r, led_g, led_b, busy, done, color_idx};
      exp = {{NL{m_led[0]}}, {NL{m_led[1]}}, {NL{m_led[2]}},
             m_busy, m_done, 3'(m_idx)};
      chk("cycle", 32'(got), 32'(exp));
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (win) begin
         if (led_r[0]) r_hi++;
         if (led_g[0]) g_hi++;
         if (led_b[0]) b_hi++;
         if (led_r10[0]) r10_hi++;
         if (led_g10[0]) g10_hi++;
         if (led_b10[0]) b10_hi++;
      end
   endtask

   task automatic press(input logic [7:0] b);
      btn = b;
      tick();
      btn = 8'h00;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic measure(input int n);
      win = 1;
      repeat (n) tick();
      win = 0;
   endtask

   task automatic run_until_done(input string tag, input int bound);
      int n;
      n = 0;
      while (done_cnt == 0 && n < bound) begin
         tick();
         n++;
      end
      chk(tag, 32'(done_cnt == 0), 32'd0);
   endtask

   initial begin
      bit timeout;
      int n;
      rst = 1'b0; btn = 8'h00; fade_en = 1'b0; win = 0;
      model_reset();
      clr_stats();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", 32'({led_r, led_g, led_b, busy, done, color_idx}), 32'd0);
      rst = 1'b1;

      // idle after reset
      win = 1;
      repeat (600) tick();
      win = 0;
      chk("idle_leds", 32'(r_hi + g_hi + b_hi), 32'd0);
      chk("idle_busy", 32'(busy_cyc), 32'd0);
      chk("idle_idx", 32'(color_idx), 32'd0);

      // jump to red
      clr_stats();
      fade_en = 1'b0;
      press(8'h01);
      repeat (300) tick();
      measure(P);
      chk("red_r_duty", 32'(r_hi), 32'd255);
      chk("red_gb_duty", 32'(g_hi + b_hi), 32'd0);
      chk("red_busy", 32'(busy_cyc), 32'd0);
      chk("red_idx", 32'(color_idx), 32'd0);

      // fade to green from reset
      do_reset();
      clr_stats();
      fade_en = 1'b1;
      press(8'h08);
      run_until_done("green_done_to", 1500);
      chk("green_busy_len",
          32'(busy_cyc >= 255 * SD - SD && busy_cyc <= 255 * SD + SD), 32'd1);
      repeat (300) tick();
      chk("green_done_once", 32'(done_cnt), 32'd1);
      clr_stats();
      measure(P);
      chk("green_g_duty", 32'(g_hi), 32'd255);
      chk("green_idx", 32'(color_idx), 32'd3);

      // multi-hot and zero ignored
      press(8'h11);
      repeat (50) tick();
      chk("multihot_idx", 32'(color_idx), 32'd3);
      chk("multihot_busy", 32'(busy), 32'd0);

      // white fade, retarget indigo at 100
      do_reset();
      fade_en = 1'b1;
      press(8'h80);
      n = 0;
      while (m_cur[0] != 100 && n < 1000) begin
         tick();
         n++;
      end
      timeout = (m_cur[0] != 100);
      chk("wait100_to", 32'(timeout), 32'd0);
      clr_stats();
      press(8'h20);
      run_until_done("indigo_done_to", 1000);
      chk("indigo_busy_len",
          32'(busy_cyc >= 100 * SD - SD && busy_cyc <= 100 * SD + SD), 32'd1);
      chk("indigo_idx", 32'(color_idx), 32'd5);
      repeat (300) tick();
      clr_stats();
      measure(P);
      chk("indigo_b_duty", 32'(b_hi), 32'd128);
      chk("indigo_rg_duty", 32'(r_hi + g_hi), 32'd0);

      // orange jump, 10-bit width expansion
      fade_en = 1'b0;
      press(8'h02);
      repeat (2100) tick();
      clr_stats();
      measure(1024);
      chk("w10_g_duty", 32'(g10_hi), 32'(expand(102, 10)));
      chk("w10_g_409", 32'(g10_hi), 32'd409);
      chk("w10_r_duty", 32'(r10_hi), 32'd1023);
      chk("w10_b_duty", 32'(b10_hi), 32'd0);
      chk("w10_flags", 32'({busy10, done10, color_idx10}), 32'd1);

      // random presses
      for (int it = 0; it < 40; it++) begin
         fade_en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) btn = 8'($urandom);
         else btn = 8'(1 << $urandom_range(0, 7));
         tick();
         btn = 8'h00;
         repeat ($urandom_range(1, 300)) tick();
      end

      // async reset mid-fade
      do_reset();
      fade_en = 1'b1;
      press(8'h80);
      repeat (200) tick();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst", 32'({led_r, led_g, led_b, busy, done, color_idx}), 32'd0);
      chk("async_rst10",
          32'({led_r10, led_g10, led_b10, busy10, done10, color_idx10}), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold", 32'({led_r, led_g, led_b, busy, done, color_idx}), 32'd0);
      rst = 1'b1;
      repeat (300) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rgb_fade_pwm.md
# rgb_fade_pwm

Parametrised RGB LED PWM controller that replaces the fixed-width, hard-switching colour driver on the board LED bank. A one-hot button selects one of eight palette colours. Each of the R, G and B channel duties either jumps to the new colour or ramps toward it one LSB per step, giving a linear fade. Duty updates take effect only at PWM period boundaries, so there are no glitches, and every colour lane drives `N_LED` physical LEDs.

## Interface
- `PWM_W`, default 8: PWM counter and duty width. Legal range 8..16.
- `N_LED`, default 4: number of LEDs driven per colour lane.
- `STEP_DIV`, default 1024: clocks per fade step. Legal range ≥1.
- `clk` in, 1: system clock. All logic is on the rising edge.
- `rst` in, 1: asynchronous, active-low reset.
- `btn` in, 8: one-hot colour select. Bit 0..7 selects red, orange, yellow, green, blue, indigo, purple, white.
- `fade_en` in, 1: 1 means ramp to the new colour; 0 means jump to it.
- `led_r` out, `N_LED`: red lane, with all bits identical.
- `led_g` out, `N_LED`: green lane.
- `led_b` out, `N_LED`: blue lane.
- `busy` out, 1: high while any channel's current duty differs from its target.
- `done` out, 1: one-cycle pulse on the cycle after `busy` falls.
- `color_idx` out, 3: index of the last accepted colour.

## Operation
- Palette, as 8-bit {R,G,B}:
  - red {255,0,0}, orange {255,102,0}, yellow {255,255,0}, green {0,255,0}
  - blue {0,0,255}, indigo {0,0,128}, purple {128,0,128}, white {255,255,255}
- Width expansion from palette byte `v` to a `PWM_W`-bit duty: `v` followed by its top `PWM_W-8` bits, so 255 maps to all-ones and 0 maps to 0.
- Button acceptance:
  - `btn` is sampled every clock.
  - Exactly one bit set: `tgt` (the three channel targets) loads the expanded palette entry, `color_idx` loads the bit index, and the prescaler clears to 0.
  - Zero bits or more than one bit set: ignored, all state held.
  - Re-pressing the current colour reloads the same target, so there is no visible change.
- `fade_en`=0: on the accepting edge, `cur` (current duty) loads the same value as `tgt`.
- `fade_en`=1 (fade engine):
  - The prescaler counts 0..`STEP_DIV`-1 and wraps.
  - At the terminal count, each channel with `cur`≠`tgt` moves by exactly 1 toward `tgt`; channels step independently.
  - A new target accepted mid-fade is ramped to from the present `cur`; the fade never restarts from 0.
- PWM generation:
  - A free-running `PWM_W`-bit counter `cnt` wraps from 2^`PWM_W`-1 to 0.
  - Shadow duty `act` loads from `cur` only on the edge where `cnt`=all-ones.
  - Lane output, registered: all-ones if `cnt` < `act`, else 0. Duty is `act`/2^`PWM_W`, so all-ones gives 255/256 at `PWM_W`=8.
- `busy` is the registered value of (`cur`≠`tgt`) for any channel. `done` = `busy` on the previous cycle AND NOT `busy` now.
- Unsigned arithmetic throughout; steps are never applied past `tgt`.

## Timing
- Reset (`rst`=0, async): `cnt`, prescaler, `tgt`, `cur`, `act` = 0; `led_*` = 0; `busy` = 0; `done` = 0; `color_idx` = 0.
- Release: the first `cnt` increment is on the first rising edge with `rst`=1.
- Latency, button to output:
  - Edge E accepts `btn`.
  - In jump mode `cur` is valid after E.
  - `act` updates at the next edge where `cnt`=all-ones.
  - `led_*` reflects it one edge later, at the start of the new period.
- Full fade from 0 to all-ones takes (2^`PWM_W`-1)×`STEP_DIV` clocks after acceptance, ±1 prescaler period.
- `busy` rises one cycle after an accept that makes `cur`≠`tgt`.
- Reset asserted mid-fade clears everything immediately; there is no resume.
- `fade_en` is sampled per cycle. Changing it mid-fade does not snap `cur`; only the next accept in jump mode does.

## Test plan
- Reset held then released, no button → `led_*`=0 for ≥2 PWM periods; `busy`=0; `color_idx`=0.
- `fade_en`=0, `PWM_W`=8, press `btn`=8'h01 → from the next period: `led_r`=4'hF for 255 of 256 clocks and 0 for 1; `led_g`=`led_b`=0; `busy` never asserted; `color_idx`=0.
- `fade_en`=1, `STEP_DIV`=4, press green (8'h08) from reset:
  - `busy` high for 255×4 clocks (±4).
  - `cur_g` increments every 4 clocks.
  - One `done` pulse at the end.
  - Final `led_g` duty is 255/256.
- Multi-hot `btn`=8'h11, then 8'h00 → `tgt` and `color_idx` unchanged, outputs unchanged.
- Mid-fade retarget: fade to white, then press indigo when `cur`=100 → R/G ramp down from 100 to 0, B ramps 100→128, then `done`; `color_idx`=5.
- `PWM_W`=10, jump to orange → `act_g`=10'd409 ({102, 2'b01}); `led_g` high for 409 of 1024 clocks.
- Pull `rst` low mid-fade → all outputs 0 in the same cycle, without waiting for a clock edge.
